// File: rtl/tdm_demux4.sv
// Receive-side 4:1 TDM demultiplexer: rebuilds four channel words from one serial stream aligned by fsync.
// Optional trailing even-parity bit per slot when TDM_DEMUX_PARITY_EN is defined (adds par_err output).
// States: HUNT | waiting for fsync, outputs hold ; RUN | slot-aligned, assembling channel words
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               din,
    input  logic               fsync,
    output logic [4*WIDTH-1:0] out,
    output logic [3:0]         valid,
    output logic [1:0]         sel,
    output logic               frame_done,
    output logic               sync_err,
    output logic               locked
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic [3:0]         par_err
`endif
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT_LEN = WIDTH + 1;
`else
    localparam int SLOT_LEN = WIDTH;
`endif
    localparam int CW = $clog2(SLOT_LEN + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(SLOT_LEN - 1);

    typedef enum logic {HUNT, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    bitcnt;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] word;
    logic             frame_start;

    assign shift_next  = {shift[WIDTH-2:0], din};
    assign frame_start = (bitcnt == '0) && (sel == 2'd0);

    // With parity the register already holds the data when the parity bit arrives.
`ifdef TDM_DEMUX_PARITY_EN
    assign word = shift;
`else
    assign word = shift_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            bitcnt     <= '0;
            shift      <= '0;
            out        <= '0;
            valid      <= '0;
            sel        <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err    <= '0;
`endif
        end else begin
            valid      <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err    <= '0;
`endif
            if (en) begin
                case (state)
                    HUNT: begin
                        if (fsync) begin
                            shift  <= shift_next;
                            bitcnt <= CW'(1);
                            sel    <= 2'd0;
                            state  <= RUN;
                            locked <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (fsync) begin
                            // fsync anywhere but a frame start restarts slot 0 and drops the partial slot
                            sync_err <= !frame_start;
                            shift    <= shift_next;
                            bitcnt   <= CW'(1);
                            sel      <= 2'd0;
                        end else if (frame_start) begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                            locked   <= 1'b0;
                        end else begin
                            shift <= shift_next;
                            if (bitcnt == LAST_BIT) begin
                                for (int k = 0; k < 4; k++) begin
                                    if (sel == 2'(k)) begin
                                        out[k*WIDTH +: WIDTH] <= word;
                                        valid[k]              <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                                        par_err[k]            <= (^shift) ^ din;
`endif
                                    end
                                end
                                bitcnt     <= '0;
                                sel        <= sel + 2'd1;
                                frame_done <= (sel == 2'd3);
                            end else begin
                                bitcnt <= bitcnt + CW'(1);
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
